checksum_arbiter: RTL
=====================

Name: checksum_arbiter

Overview:
- Shares one incremental checksum engine (old_checksum/removed_val/new_val in, req/gnt handshake, new_checksum out) among N header-creator requesters.
- Round-robin arbitration, operand capture, one-cycle engine request pulse, wait for the engine's grant, result returned to the winning requester.
- Sits between the per-field header rewrite stages and the single checksum_gen instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 64, engine grant watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- req_valid  in  N_REQ  per-requester request; held until req_ready
- req_ready  out  N_REQ  one-hot pulse; operands of that requester captured this cycle
- req_old_checksum  in  16*N_REQ  packed; slice i = requester i
- req_removed_val  in  16*N_REQ  packed
- req_new_val  in  16*N_REQ  packed
- rsp_valid  out  N_REQ  one-hot, one-cycle result strobe
- rsp_checksum  out  16  result; valid when any rsp_valid bit is set
- rsp_error  out  1  qualifies rsp_valid; 1 = timeout (optional feature only)
- cs_old_checksum  out  16  to engine
- cs_removed_val  out  16  to engine
- cs_new_val  out  16  to engine
- cs_req  out  1  one-cycle request pulse to engine
- cs_gnt  in  1  engine done; sampled as level in WAIT
- cs_new_checksum  in  16  engine result; valid with cs_gnt
- spurious_gnt  out  1  sticky: cs_gnt seen outside WAIT

Behaviour:
- Reset values: all outputs 0, FSM = IDLE, round-robin pointer = 0, operand registers = 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, pick the first set bit at or after pointer, wrapping modulo N_REQ.
  - Assert req_ready[winner] for this cycle only.
  - Register winner id and its three 16-bit slices.
  - Set pointer = (winner+1) mod N_REQ.
  - Go to ISSUE.
- ISSUE: cs_req=1 for exactly one cycle; go to WAIT.
- Operand stability: cs_* operands are driven from the registers; they are stable from ISSUE until the cycle after leaving WAIT.
- WAIT: stay until cs_gnt=1. In that cycle, register cs_new_checksum into rsp_checksum and go to RESP.
- RESP:
  - rsp_valid[winner]=1 for one cycle; rsp_error=0.
  - rsp_checksum holds its value until the next RESP.
  - Return to IDLE.
- Throughput: a new request may be accepted in the IDLE cycle following RESP.
- Minimum latency: accept (cycle 0) -> cs_req (cycle 1) -> gnt earliest cycle 2 -> rsp_valid cycle 3.
- Fairness: with all N_REQ requesters continuously valid, grants rotate 0,1,2,...,N_REQ-1,0.
- Single requester: with only one requester valid, it wins every time, regardless of pointer.
- req_valid deasserted while not granted: no effect; no state change.
- cs_gnt in IDLE, ISSUE or RESP: ignored for the datapath; sets spurious_gnt, which is cleared only by reset.
- cs_gnt in the same cycle as ISSUE cannot complete the transaction; only WAIT samples it.
- Reset mid-operation (any state):
  - Immediate return to IDLE; outputs zeroed; no rsp_valid.
  - The in-flight engine transaction is abandoned; a cs_gnt arriving afterwards sets spurious_gnt.
- No arithmetic is performed here; data passes through at 16 bits unmodified.

Optional Feature:
- Macro: CHECKSUM_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without cs_gnt: go to RESP with rsp_error=1 and rsp_checksum = the winner's captured old_checksum.
  - cs_gnt arriving in the timeout cycle takes priority; that is a normal response.
- Not defined: no counter; WAIT waits indefinitely; rsp_error is tied to 0.

Test Plan:
- Reset, then requester 2 only sends old=16'h1234, removed=16'h0023, new=16'h0023; engine gnt 3 cycles after cs_req with 16'h1234 -> req_ready[2] cycle 0, cs_req cycle 1, rsp_valid=4'b0100 with rsp_checksum=16'h1234, rsp_error=0.
- All 4 requesters valid continuously for 8 transactions -> grant order 0,1,2,3,0,1,2,3; each rsp_valid matches its own operands echoed by the engine model.
- Pointer=3 after a grant to 2; requesters 0 and 1 valid -> 0 wins next, then 1.
- cs_gnt pulsed in IDLE -> spurious_gnt=1 and stays 1; no rsp_valid; the next normal transaction completes correctly.
- Assert reset during WAIT, then the engine raises gnt -> no rsp_valid, FSM in IDLE, spurious_gnt=1; the subsequent request completes normally.
- With CHECKSUM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=10, engine never grants, old=16'h5a5a -> rsp_valid after 10 WAIT cycles, rsp_error=1, rsp_checksum=16'h5a5a; without the macro, the FSM remains in WAIT.

Source files
------------

// File: rtl/checksum_arbiter.sv
// Round-robin arbiter sharing one incremental checksum engine among N_REQ requesters.
// Optional engine-grant watchdog enabled by defining CHECKSUM_ARB_TIMEOUT_EN.
module checksum_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [16*N_REQ-1:0]   req_old_checksum,
  input  logic [16*N_REQ-1:0]   req_removed_val,
  input  logic [16*N_REQ-1:0]   req_new_val,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [15:0]           rsp_checksum,
  output logic                  rsp_error,
  output logic [15:0]           cs_old_checksum,
  output logic [15:0]           cs_removed_val,
  output logic [15:0]           cs_new_val,
  output logic                  cs_req,
  input  logic                  cs_gnt,
  input  logic [15:0]           cs_new_checksum,
  output logic                  spurious_gnt
);

  localparam int PW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("checksum_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win_q, win_d;
  logic [15:0]   old_q, old_d;
  logic [15:0]   rem_q, rem_d;
  logic [15:0]   new_q, new_d;
  logic [15:0]   rsp_cs_q, rsp_cs_d;
  logic          spur_q, spur_d;
`ifdef CHECKSUM_ARB_TIMEOUT_EN
  logic [15:0]   cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  logic          grant_found;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] cand;

  // First valid requester at or after the pointer, wrapping modulo N_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = PW'((k + 32'(ptr_q)) % N_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      old_q    <= '0;
      rem_q    <= '0;
      new_q    <= '0;
      rsp_cs_q <= '0;
      spur_q   <= 1'b0;
`ifdef CHECKSUM_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      old_q    <= old_d;
      rem_q    <= rem_d;
      new_q    <= new_d;
      rsp_cs_q <= rsp_cs_d;
      spur_q   <= spur_d;
`ifdef CHECKSUM_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    old_d    = old_q;
    rem_d    = rem_q;
    new_d    = new_q;
    rsp_cs_d = rsp_cs_q;
    spur_d   = spur_q | (cs_gnt && state_q != WAIT);
`ifdef CHECKSUM_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: if (grant_found) begin
        win_d   = grant_idx;
        old_d   = req_old_checksum[grant_idx*16 +: 16];
        rem_d   = req_removed_val[grant_idx*16 +: 16];
        new_d   = req_new_val[grant_idx*16 +: 16];
        ptr_d   = PW'((32'(grant_idx) + 1) % N_REQ);
        state_d = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef CHECKSUM_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (cs_gnt) begin
          rsp_cs_d = cs_new_checksum;
          state_d  = RESP;
`ifdef CHECKSUM_ARB_TIMEOUT_EN
          err_d    = 1'b0;
        end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          // Timeout answers with the requester's own old checksum.
          rsp_cs_d = old_q;
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d    = cnt_q + 16'd1;
`endif
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    cs_req    = 1'b0;
    rsp_error = 1'b0;
    case (state_q)
      IDLE:  if (grant_found && !reset) req_ready[grant_idx] = 1'b1;
      ISSUE: cs_req = 1'b1;
      RESP: begin
        rsp_valid[win_q] = 1'b1;
`ifdef CHECKSUM_ARB_TIMEOUT_EN
        rsp_error = err_q;
`endif
      end
      default: ;
    endcase
  end

  assign cs_old_checksum = old_q;
  assign cs_removed_val  = rem_q;
  assign cs_new_val      = new_q;
  assign rsp_checksum    = rsp_cs_q;
  assign spurious_gnt    = spur_q;

endmodule
